// File: rtl/lane_scheduler_rr.sv
// lane_scheduler_rr
//   Four-lane round-robin scheduler that merges lane byte streams into one
//   registered output stream. An arbitration win may lock the winning lane
//   for up to BURST consecutive beats.
//
// Parameters
//   IDLE_BYTE  filler byte driven on data_out when no beat is transferred
//   BURST      max consecutive beats per arbitration win (1..8)
//
// Ports
//   clk_4f                 clock, rising edge
//   reset                  synchronous, active-high
//   lane_en[3:0]           per-lane enable mask
//   data_0..data_3         lane payload bytes
//   valid_0..valid_3       lane offers a beat
//   ready_0..ready_3       combinational accept strobes (at most one high)
//   data_out               registered muxed byte
//   valid_out              registered flag, data_out is a real beat
//   lane_out               registered source lane of data_out
module lane_scheduler_rr #(
    parameter logic [7:0] IDLE_BYTE = 8'hBC,
    parameter int         BURST     = 1
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [3:0] lane_en,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] data_3,
    input  logic       valid_0,
    input  logic       valid_1,
    input  logic       valid_2,
    input  logic       valid_3,
    output logic       ready_0,
    output logic       ready_1,
    output logic       ready_2,
    output logic       ready_3,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_out
);
    localparam int NUM_LANES = 4;

    typedef enum logic {ARB, LOCK} state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_owner;
    logic [2:0] r_cnt;

    logic [NUM_LANES-1:0] w_valid;
    logic [NUM_LANES-1:0] w_elig;
    logic [NUM_LANES-1:0] w_rdy;
    logic [7:0]           w_data [NUM_LANES];
    logic                 w_gnt_vld;
    logic [1:0]           w_gnt_idx;
    logic [1:0]           w_cand;
    logic                 w_xfer;
    logic                 w_last;

    assign w_valid   = {valid_3, valid_2, valid_1, valid_0};
    assign w_data[0] = data_0;
    assign w_data[1] = data_1;
    assign w_data[2] = data_2;
    assign w_data[3] = data_3;

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            assign w_elig[k] = w_valid[k] & lane_en[k];
            assign w_rdy[k]  = ~reset & w_gnt_vld & (w_gnt_idx == 2'(k));
        end
    endgenerate

    assign ready_0 = w_rdy[0];
    assign ready_1 = w_rdy[1];
    assign ready_2 = w_rdy[2];
    assign ready_3 = w_rdy[3];

    // Grant selection. In ARB the loop runs from the farthest offset down to
    // offset 0 so the eligible lane closest to ptr is the last one written.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_ptr;
        w_cand    = r_ptr;
        if (r_state == LOCK) begin
            w_gnt_vld = w_elig[r_owner];
            w_gnt_idx = r_owner;
        end else begin
            for (int i = NUM_LANES - 1; i >= 0; i--) begin
                w_cand = r_ptr + 2'(i);
                if (w_elig[w_cand]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = w_cand;
                end
            end
        end
    end

    assign w_xfer = w_gnt_vld & ~reset;
    // Widened so BURST=8 compares correctly against a 3-bit counter.
    assign w_last = (({1'b0, r_cnt} + 4'd1) == 4'(BURST));

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
            lane_out  <= 2'd0;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_cnt     <= 3'd0;
            r_state   <= ARB;
        end else begin
            // Output stage: lane_out holds its last value on idle edges.
            if (w_xfer) begin
                data_out  <= w_data[w_gnt_idx];
                valid_out <= 1'b1;
                lane_out  <= w_gnt_idx;
            end else begin
                data_out  <= IDLE_BYTE;
                valid_out <= 1'b0;
            end

            case (r_state)
                ARB: begin
                    if (w_xfer) begin
                        if (BURST == 1) begin
                            r_ptr <= w_gnt_idx + 2'd1;
                        end else begin
                            r_owner <= w_gnt_idx;
                            r_cnt   <= 3'd1;
                            r_state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    // An owner that stops offering (or is disabled) forfeits
                    // the rest of its burst.
                    if (w_xfer && !w_last) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else begin
                        r_ptr   <= r_owner + 2'd1;
                        r_cnt   <= 3'd0;
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_lane_scheduler_rr.sv
module tb_lane_scheduler_rr;
    localparam logic [7:0] IDLE = 8'hBC;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [3:0] lane_en;
    logic [3:0] vld;
    logic [7:0] d [4];

    // Instance 0: BURST=1, instance 1: BURST=4, both fed the same stimulus.
    logic [3:0] rdy  [2];
    logic [7:0] dout [2];
    logic       vout [2];
    logic [1:0] lout [2];
    logic       r1_0, r1_1, r1_2, r1_3, r4_0, r4_1, r4_2, r4_3;
    int         bsz  [2] = '{1, 4};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_4f = ~clk_4f;

    lane_scheduler_rr #(.IDLE_BYTE(IDLE), .BURST(1)) u_b1 (
        .clk_4f(clk_4f), .reset(reset), .lane_en(lane_en),
        .data_0(d[0]), .data_1(d[1]), .data_2(d[2]), .data_3(d[3]),
        .valid_0(vld[0]), .valid_1(vld[1]), .valid_2(vld[2]), .valid_3(vld[3]),
        .ready_0(r1_0), .ready_1(r1_1), .ready_2(r1_2), .ready_3(r1_3),
        .data_out(dout[0]), .valid_out(vout[0]), .lane_out(lout[0]));

    lane_scheduler_rr #(.IDLE_BYTE(IDLE), .BURST(4)) u_b4 (
        .clk_4f(clk_4f), .reset(reset), .lane_en(lane_en),
        .data_0(d[0]), .data_1(d[1]), .data_2(d[2]), .data_3(d[3]),
        .valid_0(vld[0]), .valid_1(vld[1]), .valid_2(vld[2]), .valid_3(vld[3]),
        .ready_0(r4_0), .ready_1(r4_1), .ready_2(r4_2), .ready_3(r4_3),
        .data_out(dout[1]), .valid_out(vout[1]), .lane_out(lout[1]));

    assign rdy[0] = {r1_3, r1_2, r1_1, r1_0};
    assign rdy[1] = {r4_3, r4_2, r4_1, r4_0};

    // Reference model: next lane to search from, current owner and the number
    // of beats the owner may still take (0 means arbitrating).
    int         m_ptr [2];
    int         m_own [2];
    int         m_left[2];
    logic [7:0] m_dout[2];
    logic       m_vout[2];
    logic [1:0] m_lout[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int pick(input int j);
        logic [3:0] el;
        el = vld & lane_en;
        if (reset) return -1;
        if (m_left[j] > 0) return el[m_own[j]] ? m_own[j] : -1;
        for (int i = 0; i < 4; i++)
            if (el[(m_ptr[j] + i) % 4]) return (m_ptr[j] + i) % 4;
        return -1;
    endfunction

    task automatic step(input int j);
        int g;
        g = pick(j);
        if (reset) begin
            m_ptr[j] = 0; m_own[j] = 0; m_left[j] = 0;
            m_dout[j] = IDLE; m_vout[j] = 1'b0; m_lout[j] = 2'd0;
            return;
        end
        if (m_left[j] > 0) begin
            if (g >= 0) begin
                m_left[j]--;
                if (m_left[j] == 0) m_ptr[j] = (m_own[j] + 1) % 4;
            end else begin
                m_left[j] = 0;
                m_ptr[j]  = (m_own[j] + 1) % 4;
            end
        end else if (g >= 0) begin
            if (bsz[j] == 1) m_ptr[j] = (g + 1) % 4;
            else begin
                m_own[j]  = g;
                m_left[j] = bsz[j] - 1;
            end
        end
        if (g >= 0) begin
            m_dout[j] = d[g]; m_vout[j] = 1'b1; m_lout[j] = 2'(g);
        end else begin
            m_dout[j] = IDLE; m_vout[j] = 1'b0;
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] e, input logic [3:0] v);
        int g;
        logic [3:0] er;
        @(negedge clk_4f);
        reset = rst; lane_en = e; vld = v;
        #1;
        for (int j = 0; j < 2; j++) begin
            g  = pick(j);
            er = (g >= 0) ? 4'(1 << g) : 4'd0;
            chk($sformatf("ready_b%0d", bsz[j]), 32'(rdy[j]), 32'(er));
        end
        @(posedge clk_4f);
        for (int j = 0; j < 2; j++) step(j);
        #1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("data_out_b%0d", bsz[j]),  32'(dout[j]), 32'(m_dout[j]));
            chk($sformatf("valid_out_b%0d", bsz[j]), 32'(vout[j]), 32'(m_vout[j]));
            chk($sformatf("lane_out_b%0d", bsz[j]),  32'(lout[j]), 32'(m_lout[j]));
        end
    endtask

    initial begin
        reset = 1'b1; lane_en = 4'h0; vld = 4'h0;
        d[0] = 8'hFF; d[1] = 8'hEE; d[2] = 8'hDD; d[3] = 8'hCC;
        for (int j = 0; j < 2; j++) begin
            m_ptr[j] = 0; m_own[j] = 0; m_left[j] = 0;
            m_dout[j] = 8'h00; m_vout[j] = 1'b0; m_lout[j] = 2'd0;
        end
        cyc(1'b1, 4'hF, 4'hF);
        cyc(1'b1, 4'hF, 4'hF);
        // Explicit reset-state checks against constants.
        chk("rst_data_out", 32'(dout[1]), 32'(IDLE));
        chk("rst_valid_out", 32'(vout[1]), 32'd0);
        chk("rst_lane_out", 32'(lout[1]), 32'd0);

        // All lanes valid: round robin (B1) and 4-beat bursts (B4).
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'hF, 4'hF);
        // Only lanes 2 and 3 valid.
        d[2] = 8'h77; d[3] = 8'h66;
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'hF, 4'b1100);
        // Nothing valid: idle, pointer holds.
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'hF, 4'h0);
        // Owner 0 drops after two beats -> idle cycle, then lane 1.
        cyc(1'b1, 4'hF, 4'hF);
        cyc(1'b0, 4'hF, 4'hF);
        cyc(1'b0, 4'hF, 4'hF);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'hF, 4'b1110);
        // lane_en drop on the owner mid-burst.
        cyc(1'b0, 4'hF, 4'hF);
        cyc(1'b0, 4'hB, 4'hF);
        // Reset mid-burst on lane 2, then lane 0 served first.
        cyc(1'b1, 4'hF, 4'hF);
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'hF, 4'hF);
        cyc(1'b1, 4'hF, 4'hF);
        chk("midburst_rst_lane", 32'(lout[1]), 32'd0);
        chk("midburst_rst_vld", 32'(vout[1]), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'hF, 4'hF);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lane_scheduler_rr.md
LANE_SCHEDULER_RR -- requirements
Module: lane_scheduler_rr

Interface
REQ-001 Parameter IDLE_BYTE, default 8'hBC, is the filler byte driven on data_out when no beat is transferred.
REQ-002 Parameter BURST, default 1, legal 1..8, is the maximum number of consecutive beats granted to one lane per arbitration win.
REQ-003 Port clk_4f  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the reset: one clock; reset is synchronous and active-high.
REQ-005 Port lane_en  input  4  is the per-lane enable mask, sampled every cycle; bit k gates lane k.
REQ-006 Ports data_0..data_3  input  8 each  carry the lane payload bytes.
REQ-007 Ports valid_0..valid_3  input  1 each  flag that the lane offers a beat; valid SHALL NOT depend on ready.
REQ-008 Ports ready_0..ready_3  output  1 each  are combinational accept strobes; a beat transfers on an edge where valid_k=1 and ready_k=1.
REQ-009 Port data_out  output  8  is the registered muxed byte stream.
REQ-010 Port valid_out  output  1  is the registered flag marking data_out as a real beat.
REQ-011 Port lane_out  output  2  is the registered source lane index of data_out.

Function
REQ-012 A lane k SHALL be eligible when valid_k=1 and lane_en[k]=1.
REQ-013 The block SHALL keep a 2-bit round-robin pointer ptr, a state {ARB, LOCK}, an owner index, and a 3-bit burst counter cnt.
REQ-014 In ARB, the block SHALL grant the first eligible lane searching ptr, ptr+1, ptr+2, ptr+3 (mod 4) and assert only that lane's ready.
REQ-015 At most one ready SHALL be high in any cycle.
REQ-016 On a granted edge in ARB with BURST=1, ptr SHALL become granted+1 mod 4 and state SHALL stay ARB.
REQ-017 On a granted edge in ARB with BURST>1, owner SHALL become the granted lane, cnt SHALL become 1, and state SHALL become LOCK.
REQ-018 In LOCK, only the owner SHALL be considered; ready_owner SHALL equal owner eligibility, and every other ready SHALL be 0.
REQ-019 In LOCK, each transferred beat SHALL increment cnt; the beat that makes cnt equal BURST SHALL set ptr=owner+1 mod 4, cnt=0, and state=ARB.
REQ-020 In LOCK, if the owner is not eligible, no beat SHALL transfer (one idle cycle); ptr SHALL become owner+1 mod 4, cnt=0, and state=ARB.
REQ-021 In ARB with no eligible lane, ptr and state SHALL hold and every ready SHALL be 0.
REQ-022 Latency SHALL be exactly one cycle: a beat accepted on edge N SHALL appear on data_out, valid_out=1, and lane_out=k from edge N until edge N+1.
REQ-023 On any edge without a transfer, data_out SHALL load IDLE_BYTE, valid_out SHALL load 0, and lane_out SHALL hold.
REQ-024 ptr and owner arithmetic SHALL wrap modulo 4: lane 3 +1 gives lane 0.
REQ-025 A lane_en bit falling while its lane owns LOCK SHALL be treated as owner ineligible (REQ-020).

Reset
REQ-026 While reset=1, all ready outputs SHALL be forced to 0 combinationally.
REQ-027 On an edge with reset=1, the block SHALL load data_out=IDLE_BYTE, valid_out=0, lane_out=0, ptr=0, owner=0, cnt=0, and state=ARB, overriding any transfer or burst in progress.
REQ-028 The first arbitration after reset release SHALL start its search at lane 0.

Verification
REQ-029 BURST=1, lane_en=4'hF, all valid, data 8'hFF/EE/DD/CC held -> data_out FF,EE,DD,CC repeating; lane_out 0,1,2,3; valid_out 1 every cycle after the first.
REQ-030 BURST=1, valid_0=valid_1=0, lanes 2 and 3 valid with 8'h77/66 -> data_out alternates 77,66; ready_0 and ready_1 are never asserted.
REQ-031 No lane valid -> data_out=8'hBC, valid_out=0, all ready 0, ptr unchanged.
REQ-032 BURST=4, all lanes valid -> 4 beats from lane 0, then 4 from lane 1, and so on; lane_out changes every 4 beats.
REQ-033 BURST=4, valid_0 drops after 2 beats -> one idle cycle (8'hBC, valid_out=0), then lane 1 is served.
REQ-034 reset asserted mid-burst on lane 2 -> next cycle data_out=8'hBC, valid_out=0, lane_out=0; after release, lane 0 is served first if valid.
